mips_cpu_mem_arbiter: RTL and testbench
=======================================

Name: mips_cpu_mem_arbiter

Overview:
- Shares one Avalon-style memory port between the CPU's instruction-fetch requester and data requester.
- Gives each requester a req/ack handshake with registered read data.
- Drives a single memory master interface and tolerates arbitrary waitrequest stalls.
- Provides a bus-timeout error flag.
- Sits between mips_cpu core request logic and the unified memory / testbench RAM.

Parameters:
- DATA_PRIORITY, 1: 1 = data requester wins every simultaneous request; 0 = round-robin between requesters.
- TIMEOUT_CYCLES, 1023: consecutive waitrequest-high cycles before a transaction is aborted; 0 disables the timeout.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-low (0 = reset), sampled on posedge clk.
- i_req  in  1  instruction fetch request, held high until i_ack.
- i_addr  in  32  fetch byte address.
- i_ack  out  1  one-cycle pulse: fetch complete, i_rdata valid.
- i_rdata  out  32  fetched word, held until the next i_ack.
- d_req  in  1  data request, held high until d_ack.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  32  data byte address.
- d_byteenable  in  4  byte lanes for the access.
- d_wdata  in  32  write data.
- d_ack  out  1  one-cycle pulse: data access complete.
- d_rdata  out  32  read word, held until the next d_ack.
- mem_address  out  32  word-aligned address (bits [1:0] forced to 0).
- mem_read  out  1  read strobe.
- mem_write  out  1  write strobe.
- mem_byteenable  out  4  byte lanes (4'b1111 for fetches).
- mem_writedata  out  32  write data.
- mem_waitrequest  in  1  slave stall.
- mem_readdata  in  32  read data, valid in a cycle where mem_read=1 and waitrequest=0.
- bus_err  out  1  sticky timeout flag.
- busy  out  1  high while a transaction is in flight.

Behaviour:
- Reset (reset=0 at posedge):
  - state=IDLE.
  - mem_read, mem_write, i_ack, d_ack, bus_err, busy = 0.
  - mem_address, mem_writedata, i_rdata, d_rdata = 0; mem_byteenable = 0.
  - last_grant = instruction; timeout counter = 0.
  - Reset mid-transaction drops the strobes at that edge; no ack is issued.
- States: IDLE, IBUS, DBUS, ACK.
- IDLE:
  - Samples i_req and d_req.
  - If only one is high, that requester is granted.
  - If both are high: DATA_PRIORITY=1 grants data; otherwise the requester not in last_grant is granted.
  - On grant, all mem_* outputs are registered from the requester's inputs at that edge, and busy=1.
  - Latency: request seen in cycle N, mem strobe high in cycle N+1.
- IBUS/DBUS:
  - The strobe and address are held stable while mem_waitrequest=1.
  - At the first edge with mem_waitrequest=0:
    - strobe deasserts;
    - a read captures mem_readdata into i_rdata or d_rdata;
    - the matching ack is asserted for exactly one cycle (cycle following completion);
    - last_grant is updated; go to ACK.
- Minimum latency is req→ack = 2 cycles with zero wait states.
- ACK:
  - ack=1 for this single cycle; busy=0.
  - Requests are not sampled this cycle, so the requester can drop req. Return to IDLE.
  - Back-to-back transactions therefore start every 3 cycles minimum.
- Timeout: the counter increments each IBUS/DBUS cycle with waitrequest=1 and clears on grant. When it reaches TIMEOUT_CYCLES:
  - strobes drop; bus_err is set (sticky until reset);
  - a read returns 32'hFFFFFFFF in rdata;
  - ack still pulses, so the core never hangs.
- Requester dropping req mid-transaction: the transaction completes on the memory side and the ack still pulses; the requester ignores it.
- The request inputs are only sampled at grant; changes afterwards are ignored.
- Misaligned addresses are not checked; bits [1:0] are dropped, and the byte lane is the requester's job via d_byteenable.
- Never mem_read and mem_write simultaneously (assertion).

Decomposition:
- Package mips_cpu_pkg holds:
  - arb_state_t enum (IDLE=2'b00, IBUS=2'b01, DBUS=2'b10, ACK=2'b11);
  - grant_t enum (GRANT_I, GRANT_D);
  - constant BUS_ERR_DATA = 32'hFFFFFFFF.
- One natural sub-module, mips_cpu_bus_timeout: counter with clear/enable/expired, parameterised by TIMEOUT_CYCLES.
- Arbitration and FSM stay in the top module.

Test Plan:
- Fetch only, zero wait, i_addr=32'hBFC00003, mem_readdata=32'h24020005:
  - mem_read high one cycle at address 32'hBFC00000, byteenable 4'b1111;
  - i_ack pulses 2 cycles after req; i_rdata=32'h24020005.
- Data write with 3 wait states, d_addr=32'h00001004, d_wdata=32'hDEADBEEF, be=4'b0011:
  - mem_write and data stable for 4 cycles;
  - d_ack the cycle after waitrequest falls; i_ack stays 0.
- Simultaneous i_req and d_req, DATA_PRIORITY=1:
  - data served first, then fetch;
  - acks separated by at least 3 cycles.
  - Repeat with DATA_PRIORITY=0 over 4 rounds: grants alternate D, I, D, I.
- waitrequest stuck high, TIMEOUT_CYCLES=8, data read:
  - strobe drops after 8 stall cycles; bus_err=1;
  - d_ack pulses with d_rdata=32'hFFFFFFFF; bus_err persists until reset.
- reset=0 asserted during DBUS:
  - next cycle all strobes, acks and busy are 0; no d_ack ever pulses;
  - after reset=1 a fresh fetch completes normally.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// Shared types and constants for the mips_cpu memory-side logic.
package mips_cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        IBUS = 2'b01,
        DBUS = 2'b10,
        ACK  = 2'b11
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    localparam logic [31:0] BUS_ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/mips_cpu_bus_timeout.sv
// Stall counter: expired_o fires on the TIMEOUT_CYCLES-th consecutive enabled cycle.
module mips_cpu_bus_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int unsigned LIMIT = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Firing while the counter shows LIMIT makes the strobe last exactly TIMEOUT_CYCLES stall cycles.
    assign expired_o = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q == CNT_W'(LIMIT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mips_cpu_mem_arbiter.sv
// Arbitrates the instruction-fetch and data requesters onto one Avalon-style memory master.
module mips_cpu_mem_arbiter
    import mips_cpu_pkg::*;
#(
    parameter int unsigned DATA_PRIORITY  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        i_ack,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [3:0]  d_byteenable,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byteenable,
    output logic [31:0] mem_writedata,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic        bus_err,
    output logic        busy
);

    arb_state_t  state_q, state_d;
    grant_t      last_grant_q, last_grant_d;
    logic [31:0] addr_q, addr_d;
    logic        rd_q, rd_d;
    logic        wr_q, wr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] i_rdata_q, i_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;
    logic        bus_err_q, bus_err_d;
    logic        to_clr, to_en, to_expired;
    logic        grant_data;
    logic [31:0] rdata_sel;
    logic        unused_addr_lsbs;

    // Byte offset is dropped on the way out; lane selection is the requester's job.
    assign unused_addr_lsbs = ^{i_addr[1:0], d_addr[1:0]};

    mips_cpu_bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .reset    (reset),
        .clr_i    (to_clr),
        .en_i     (to_en),
        .expired_o(to_expired)
    );

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        rd_d         = rd_q;
        wr_d         = wr_q;
        be_d         = be_q;
        wdata_d      = wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;
        bus_err_d    = bus_err_q;
        to_clr       = 1'b0;
        to_en        = 1'b0;
        rdata_sel    = mem_waitrequest ? BUS_ERR_DATA : mem_readdata;
        // On a tie, round-robin hands the bus to whoever was not served last.
        grant_data   = d_req && (!i_req || (DATA_PRIORITY != 0) || (last_grant_q == GRANT_I));

        case (state_q)
            IDLE: begin
                if (grant_data) begin
                    state_d = DBUS;
                    to_clr  = 1'b1;
                    addr_d  = {d_addr[31:2], 2'b00};
                    rd_d    = !d_we;
                    wr_d    = d_we;
                    be_d    = d_byteenable;
                    wdata_d = d_wdata;
                end else if (i_req) begin
                    state_d = IBUS;
                    to_clr  = 1'b1;
                    addr_d  = {i_addr[31:2], 2'b00};
                    rd_d    = 1'b1;
                    wr_d    = 1'b0;
                    be_d    = 4'b1111;
                    wdata_d = '0;
                end
            end
            IBUS, DBUS: begin
                to_en = mem_waitrequest;
                if (!mem_waitrequest || to_expired) begin
                    state_d      = ACK;
                    rd_d         = 1'b0;
                    wr_d         = 1'b0;
                    last_grant_d = (state_q == DBUS) ? GRANT_D : GRANT_I;
                    if (rd_q) begin
                        if (state_q == DBUS) d_rdata_d = rdata_sel;
                        else                 i_rdata_d = rdata_sel;
                    end
                    if (mem_waitrequest) bus_err_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_I;
            addr_q       <= '0;
            rd_q         <= 1'b0;
            wr_q         <= 1'b0;
            be_q         <= '0;
            wdata_q      <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
            bus_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            rd_q         <= rd_d;
            wr_q         <= wr_d;
            be_q         <= be_d;
            wdata_q      <= wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
            bus_err_q    <= bus_err_d;
        end
    end

    assign mem_address    = addr_q;
    assign mem_read       = rd_q;
    assign mem_write      = wr_q;
    assign mem_byteenable = be_q;
    assign mem_writedata  = wdata_q;
    assign i_rdata        = i_rdata_q;
    assign d_rdata        = d_rdata_q;
    assign bus_err        = bus_err_q;
    assign busy           = (state_q == IBUS) || (state_q == DBUS);
    assign i_ack          = (state_q == ACK) && (last_grant_q == GRANT_I);
    assign d_ack          = (state_q == ACK) && (last_grant_q == GRANT_D);

    a_rw_exclusive: assert property (@(posedge clk) disable iff (!reset) !(mem_read && mem_write));

endmodule

// File: tb/tb_mips_cpu_mem_arbiter.sv
// Directed bench: a data-priority arbiter and a round-robin arbiter share one stimulus stream.
module tb_mips_cpu_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req, d_req, d_we, mem_waitrequest;
    logic [31:0] i_addr, d_addr, d_wdata, mem_readdata;
    logic [3:0]  d_byteenable;

    logic        i_ack, d_ack, mem_read, mem_write, bus_err, busy;
    logic [31:0] i_rdata, d_rdata, mem_address, mem_writedata;
    logic [3:0]  mem_byteenable;

    logic        rr_i_ack, rr_d_ack, rr_mem_read, rr_mem_write, rr_bus_err, rr_busy;
    logic [31:0] rr_i_rdata, rr_d_rdata, rr_mem_address, rr_mem_writedata;
    logic [3:0]  rr_mem_byteenable;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mips_cpu_mem_arbiter #(.DATA_PRIORITY(1), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_byteenable(d_byteenable),
        .d_wdata(d_wdata), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
        .bus_err(bus_err), .busy(busy)
    );

    mips_cpu_mem_arbiter #(.DATA_PRIORITY(0), .TIMEOUT_CYCLES(8)) rr (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(rr_i_ack), .i_rdata(rr_i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_byteenable(d_byteenable),
        .d_wdata(d_wdata), .d_ack(rr_d_ack), .d_rdata(rr_d_rdata),
        .mem_address(rr_mem_address), .mem_read(rr_mem_read), .mem_write(rr_mem_write),
        .mem_byteenable(rr_mem_byteenable), .mem_writedata(rr_mem_writedata),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
        .bus_err(rr_bus_err), .busy(rr_busy)
    );

    task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        logic exp_d;
        reset = 1'b0; i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0;
        d_addr = '0; d_byteenable = '0; d_wdata = '0;
        mem_waitrequest = 1'b0; mem_readdata = '0;
        cyc(); cyc();

        // reset state
        chk_vec("rst_read", mem_read, 0);      chk_vec("rst_write", mem_write, 0);
        chk_vec("rst_iack", i_ack, 0);         chk_vec("rst_dack", d_ack, 0);
        chk_vec("rst_buserr", bus_err, 0);     chk_vec("rst_busy", busy, 0);
        chk_vec("rst_addr", mem_address, 0);   chk_vec("rst_wdata", mem_writedata, 0);
        chk_vec("rst_be", mem_byteenable, 0);  chk_vec("rst_irdata", i_rdata, 0);
        chk_vec("rst_drdata", d_rdata, 0);
        reset = 1'b1;
        cyc();

        // fetch, zero wait states
        i_req = 1'b1; i_addr = 32'hBFC0_0003; mem_readdata = 32'h2402_0005;
        cyc();
        chk_vec("f_read", mem_read, 1);        chk_vec("f_addr", mem_address, 32'hBFC0_0000);
        chk_vec("f_be", mem_byteenable, 4'hF); chk_vec("f_busy", busy, 1);
        chk_vec("f_ack_early", i_ack, 0);
        cyc();
        chk_vec("f_ack", i_ack, 1);            chk_vec("f_rdata", i_rdata, 32'h2402_0005);
        chk_vec("f_read_off", mem_read, 0);    chk_vec("f_busy_ack", busy, 0);
        i_req = 1'b0; mem_readdata = '0;
        cyc();
        chk_vec("f_ack_pulse", i_ack, 0);      chk_vec("f_rdata_hold", i_rdata, 32'h2402_0005);

        // data write, 3 wait states; request fields change after grant and must be ignored
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_1004; d_wdata = 32'hDEAD_BEEF;
        d_byteenable = 4'b0011; mem_waitrequest = 1'b1;
        cyc();
        d_addr = 32'hFFFF_FFF0; d_wdata = '0; d_byteenable = 4'b1100;
        for (int k = 1; k <= 4; k++) begin
            chk_vec("w_write", mem_write, 1);      chk_vec("w_read", mem_read, 0);
            chk_vec("w_addr", mem_address, 32'h0000_1004);
            chk_vec("w_data", mem_writedata, 32'hDEAD_BEEF);
            chk_vec("w_be", mem_byteenable, 4'b0011);
            chk_vec("w_dack_early", d_ack, 0);
            if (k == 4) mem_waitrequest = 1'b0;
            cyc();
        end
        chk_vec("w_dack", d_ack, 1);           chk_vec("w_iack", i_ack, 0);
        chk_vec("w_write_off", mem_write, 0);
        d_req = 1'b0; d_we = 1'b0;
        cyc();
        chk_vec("w_dack_pulse", d_ack, 0);

        // simultaneous requests, data priority
        i_req = 1'b1; i_addr = 32'h0000_0100; d_req = 1'b1; d_addr = 32'h0000_2000;
        d_byteenable = 4'hF; mem_readdata = 32'h1111_1111;
        cyc();
        chk_vec("p_addr_d", mem_address, 32'h0000_2000); chk_vec("p_read_d", mem_read, 1);
        cyc();
        chk_vec("p_dack", d_ack, 1);           chk_vec("p_iack_0", i_ack, 0);
        chk_vec("p_drdata", d_rdata, 32'h1111_1111);
        d_req = 1'b0; mem_readdata = 32'h2222_2222;
        cyc();
        chk_vec("p_gap_d", d_ack, 0);          chk_vec("p_gap_i", i_ack, 0);
        chk_vec("p_gap_busy", busy, 0);
        cyc();
        chk_vec("p_addr_i", mem_address, 32'h0000_0100); chk_vec("p_gap_i2", i_ack, 0);
        cyc();
        chk_vec("p_iack", i_ack, 1);           chk_vec("p_irdata", i_rdata, 32'h2222_2222);
        chk_vec("p_drdata_hold", d_rdata, 32'h1111_1111);
        i_req = 1'b0;
        cyc();

        // round-robin over 4 rounds (fresh last_grant), requests held high throughout
        reset = 1'b0;
        cyc();
        reset = 1'b1; i_req = 1'b1; d_req = 1'b1; i_addr = 32'h0000_0040; d_addr = 32'h0000_0080;
        mem_readdata = 32'h7777_7777;
        for (int r = 0; r < 4; r++) begin
            exp_d = (r % 2 == 0);
            cyc();
            chk_vec("rr_addr", rr_mem_address, exp_d ? 32'h0000_0080 : 32'h0000_0040);
            cyc();
            chk_vec("rr_dack", rr_d_ack, exp_d);
            chk_vec("rr_iack", rr_i_ack, !exp_d);
            chk_vec("dp_dack", d_ack, 1);
            if (r == 3) begin
                i_req = 1'b0; d_req = 1'b0;
            end
            cyc();
        end

        // data read with waitrequest stuck high
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0300; mem_waitrequest = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk_vec("to_read", mem_read, 1);
            chk_vec("to_err_early", bus_err, 0);
        end
        cyc();
        chk_vec("to_read_off", mem_read, 0);   chk_vec("to_dack", d_ack, 1);
        chk_vec("to_rdata", d_rdata, 32'hFFFF_FFFF);
        chk_vec("to_err", bus_err, 1);
        d_req = 1'b0; mem_waitrequest = 1'b0;
        cyc();
        i_req = 1'b1; i_addr = 32'h0000_0500; mem_readdata = 32'h3333_3333;
        cyc(); cyc();
        chk_vec("to_fetch_ack", i_ack, 1);     chk_vec("to_fetch_data", i_rdata, 32'h3333_3333);
        chk_vec("to_err_sticky", bus_err, 1);
        i_req = 1'b0;
        cyc();

        // reset during a stalled data write
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0600; d_wdata = 32'h0000_0055;
        d_byteenable = 4'hF; mem_waitrequest = 1'b1;
        cyc();
        chk_vec("mr_write", mem_write, 1);     chk_vec("mr_busy", busy, 1);
        reset = 1'b0;
        cyc();
        chk_vec("mr_write_off", mem_write, 0); chk_vec("mr_read_off", mem_read, 0);
        chk_vec("mr_dack", d_ack, 0);          chk_vec("mr_iack", i_ack, 0);
        chk_vec("mr_busy_off", busy, 0);       chk_vec("mr_err_clr", bus_err, 0);
        reset = 1'b1; d_req = 1'b0; d_we = 1'b0; mem_waitrequest = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk_vec("mr_no_dack", d_ack, 0);
        end
        i_req = 1'b1; i_addr = 32'h0000_1234; mem_readdata = 32'h0BAD_F00D;
        cyc();
        chk_vec("mr_f_read", mem_read, 1);     chk_vec("mr_f_addr", mem_address, 32'h0000_1234);
        cyc();
        chk_vec("mr_f_ack", i_ack, 1);         chk_vec("mr_f_rdata", i_rdata, 32'h0BAD_F00D);
        i_req = 1'b0;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
